// File: rtl/lbp_core.sv
// Local Binary Pattern engine: scans the interior of an IMG_W x IMG_W 8-bit image
// through a pipelined read port and writes one LBP code per interior pixel.
module lbp_core #(
    parameter int unsigned IMG_W  = 128,
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gray_ready,
    output logic              gray_req,
    output logic [ADDR_W-1:0] gray_addr,
    input  logic [DATA_W-1:0] gray_data,
    output logic              lbp_valid,
    output logic [ADDR_W-1:0] lbp_addr,
    output logic [DATA_W-1:0] lbp_data,
    output logic              finish
);

    localparam int unsigned CW   = $clog2(IMG_W);
    localparam int unsigned LAST = IMG_W - 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CALC  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state, state_nx;
    logic [CW-1:0]     row, col;          // centre pixel being processed
    logic [CW-1:0]     rd_row, rd_col;    // top row / current column of the read group
    logic [1:0]        rd_ro;             // row offset of the next read within the group
    logic [1:0]        cap_ro;            // row offset of the next capture
    logic [3:0]        rd_total;          // reads in the group (9, 3, or 0 after the last pixel)
    logic [3:0]        rd_issued;
    logic [3:0]        rd_captured;
    logic [DATA_W-1:0] win [3][3];        // win[row][col], col 2 is the newest column
    logic [DATA_W-1:0] code_c;
    logic              issue_c, last_cap_c, last_pix_c;

    assign issue_c    = gray_ready && (rd_issued < rd_total) && (state != S_DONE);
    assign last_cap_c = gray_req && (rd_captured == rd_total - 4'd1);
    assign last_pix_c = (row == CW'(LAST)) && (col == CW'(LAST));

    // LBP code of the window centre, neighbour order row-major skipping the centre
    always_comb begin
        code_c    = '0;
        code_c[0] = win[0][0] >= win[1][1];
        code_c[1] = win[0][1] >= win[1][1];
        code_c[2] = win[0][2] >= win[1][1];
        code_c[3] = win[1][0] >= win[1][1];
        code_c[4] = win[1][2] >= win[1][1];
        code_c[5] = win[2][0] >= win[1][1];
        code_c[6] = win[2][1] >= win[1][1];
        code_c[7] = win[2][2] >= win[1][1];
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (gray_ready) state_nx = S_LOAD;
            S_LOAD:  if (last_cap_c) state_nx = S_CALC;
            S_CALC:  state_nx = S_WRITE;
            S_WRITE: state_nx = last_pix_c ? S_DONE : S_LOAD;
            S_DONE:  state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Read issue, window capture, scan position and registered outputs.
    // Reads for the next column are prefetched during CALC/WRITE; captures
    // land on the posedge after every gray_req cycle regardless of state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gray_req    <= 1'b0;
            gray_addr   <= '0;
            lbp_valid   <= 1'b0;
            lbp_addr    <= '0;
            lbp_data    <= '0;
            finish      <= 1'b0;
            row         <= CW'(1);
            col         <= CW'(1);
            rd_row      <= '0;
            rd_col      <= '0;
            rd_ro       <= '0;
            cap_ro      <= '0;
            rd_total    <= 4'd9;
            rd_issued   <= '0;
            rd_captured <= '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    win[i][j] <= '0;
        end else begin
            if (issue_c) begin
                gray_req  <= 1'b1;
                gray_addr <= ADDR_W'({CW'(rd_row + CW'(rd_ro)), rd_col});
                rd_issued <= rd_issued + 4'd1;
                if (rd_ro == 2'd2) begin
                    rd_ro  <= '0;
                    rd_col <= CW'(rd_col + CW'(1));
                end else begin
                    rd_ro <= rd_ro + 2'd1;
                end
            end else begin
                gray_req <= 1'b0;
            end

            if (gray_req) begin
                if (cap_ro == 2'd0) begin
                    for (int i = 0; i < 3; i++) begin
                        win[i][0] <= win[i][1];
                        win[i][1] <= win[i][2];
                    end
                end
                win[cap_ro][2] <= gray_data;
                cap_ro         <= (cap_ro == 2'd2) ? 2'd0 : cap_ro + 2'd1;
                rd_captured    <= rd_captured + 4'd1;
            end

            // Window complete: arm the read group for the following centre
            if (state == S_LOAD && last_cap_c) begin
                rd_issued   <= '0;
                rd_captured <= '0;
                if (col != CW'(LAST)) begin
                    rd_row   <= CW'(row - CW'(1));
                    rd_col   <= CW'(col + CW'(2));
                    rd_total <= 4'd3;
                end else if (row != CW'(LAST)) begin
                    rd_row   <= row;
                    rd_col   <= '0;
                    rd_total <= 4'd9;
                end else begin
                    rd_total <= 4'd0;
                end
            end

            if (state == S_CALC) begin
                lbp_data <= code_c;
                lbp_addr <= ADDR_W'({row, col});
            end

            if (state == S_WRITE) begin
                if (col != CW'(LAST)) begin
                    col <= CW'(col + CW'(1));
                end else if (row != CW'(LAST)) begin
                    row <= CW'(row + CW'(1));
                    col <= CW'(1);
                end
            end

            lbp_valid <= (state_nx == S_WRITE);
            finish    <= (state_nx == S_DONE);
        end
    end

endmodule

// File: tb/tb_lbp_core.sv
// Bench for lbp_core: host memory model, result sink and a software LBP reference.
module tb_lbp_core;

    localparam int unsigned W      = 128;
    localparam int unsigned N      = W * W;
    localparam int unsigned LAST   = 126;
    localparam int unsigned NCODES = LAST * LAST;

    logic        clk = 1'b0;
    logic        reset;
    logic        gray_ready;
    logic        gray_req;
    logic [13:0] gray_addr;
    wire  [7:0]  gray_data;
    logic        lbp_valid;
    logic [13:0] lbp_addr;
    logic [7:0]  lbp_data;
    logic        finish;

    logic [7:0]  img     [N];
    logic [7:0]  exp_mem [N];
    logic [7:0]  sink    [N];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_writes;
    int          exp_r, exp_c;
    int          cycles;
    logic        prev_valid, prev_finish;
    logic [13:0] prev_addr;

    assign gray_data = gray_req ? img[gray_addr] : 8'hzz;

    always #5 clk = ~clk;

    lbp_core dut (
        .clk        (clk),
        .reset      (reset),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference LBP straight from the definition
    function automatic logic [7:0] lbp_ref(input int r, input int c);
        logic [7:0] code;
        logic [7:0] g;
        int         p;
        code = '0;
        p    = 0;
        g    = img[r*W + c];
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (dy != 0 || dx != 0) begin
                    code[p] = (img[(r+dy)*W + (c+dx)] >= g);
                    p++;
                end
        return code;
    endfunction

    task automatic build_expected();
        for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++)
                if (r == 0 || c == 0 || r == W-1 || c == W-1) exp_mem[r*W + c] = 8'h00;
                else                                          exp_mem[r*W + c] = lbp_ref(r, c);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_gray_req"},  32'(gray_req),  32'd0);
        check({tag, "_gray_addr"}, 32'(gray_addr), 32'd0);
        check({tag, "_lbp_valid"}, 32'(lbp_valid), 32'd0);
        check({tag, "_lbp_addr"},  32'(lbp_addr),  32'd0);
        check({tag, "_lbp_data"},  32'(lbp_data),  32'd0);
        check({tag, "_finish"},    32'(finish),    32'd0);
    endtask

    // Sink memory plus per-cycle checks of the write stream and completion
    always @(negedge clk) begin
        if (!reset) begin
            n_writes    = 0;
            exp_r       = 1;
            exp_c       = 1;
            prev_valid  = 1'b0;
            prev_finish = 1'b0;
            prev_addr   = '0;
            for (int a = 0; a < N; a++) sink[a] = 8'h00;
        end else begin
            if (lbp_valid) begin
                check("write_addr", 32'(lbp_addr), 32'(exp_r*W + exp_c));
                check("write_data", 32'(lbp_data), 32'(exp_mem[lbp_addr]));
                check("valid_single_cycle", 32'(prev_valid), 32'd0);
                check("valid_before_finish", 32'(finish), 32'd0);
                sink[lbp_addr] = lbp_data;
                n_writes++;
                if (exp_c < LAST) exp_c++;
                else begin
                    exp_c = 1;
                    exp_r++;
                end
            end
            if (finish)
                check("done_quiet", 32'({gray_req, lbp_valid}), 32'd0);
            if (finish && !prev_finish) begin
                check("finish_after_last_write", 32'({prev_valid, prev_addr}),
                      32'({1'b1, 14'(LAST*W + LAST)}));
                check("finish_write_count", 32'(n_writes), 32'(NCODES));
            end
            prev_valid  = lbp_valid;
            prev_addr   = lbp_addr;
            prev_finish = finish;
        end
    end

    initial begin
        reset      = 1'b0;
        gray_ready = 1'b0;

        // Phase A: flat image, interrupted by reset
        for (int a = 0; a < N; a++) img[a] = 8'h50;
        build_expected();
        check("pin_flat_interior", 32'(exp_mem[1*W + 1]), 32'hFF);
        check("pin_flat_border",   32'(exp_mem[0]),       32'h00);

        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset");
        @(posedge clk);
        #2 reset = 1'b1;

        // Not ready yet: engine must stay idle
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 check("idle_no_req", 32'(gray_req), 32'd0);
        end
        gray_ready = 1'b1;

        repeat (4990) @(posedge clk);
        #1;
        check("progress_before_reset", 32'(n_writes > 500), 32'd1);
        check("first_flat_code", 32'(sink[1*W + 1]), 32'hFF);

        #1 reset = 1'b0;
        #1 check_outputs_zero("mid_reset");

        // Phase B: composite image covering ramp, ties, isolated peak and noise
        for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++) begin
                if (r <= 15)      img[r*W + c] = 8'(c);
                else if (r <= 40) img[r*W + c] = 8'h50;
                else if (r <= 90) img[r*W + c] = 8'h00;
                else              img[r*W + c] = 8'($urandom_range(0, 255));
            end
        img[64*W + 64] = 8'd200;
        build_expected();
        check("pin_ramp_1_1",    32'(exp_mem[1*W + 1]),   32'hD6);
        check("pin_ramp_5_40",   32'(exp_mem[5*W + 40]),  32'hD6);
        check("pin_flat_30_30",  32'(exp_mem[30*W + 30]), 32'hFF);
        check("pin_peak",        32'(exp_mem[8256]),      32'h00);
        check("pin_peak_nb_nw",  32'(exp_mem[63*W + 63]), 32'hFF);
        check("pin_peak_nb_e",   32'(exp_mem[64*W + 65]), 32'hFF);
        check("pin_peak_nb_se",  32'(exp_mem[65*W + 65]), 32'hFF);
        check("pin_zero_70_10",  32'(exp_mem[70*W + 10]), 32'hFF);

        repeat (3) @(posedge clk);
        #2 reset = 1'b1;

        cycles = 0;
        while (!finish && cycles < 65000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 20000) gray_ready = 1'b0;
            if (cycles > 20000 && cycles <= 20020)
                check("gap_no_req", 32'(gray_req), 32'd0);
            if (cycles == 20020) gray_ready = 1'b1;
        end
        check("finish_within_65000", 32'(finish), 32'd1);

        repeat (5) @(posedge clk);
        #1 check("finish_sticky", 32'(finish), 32'd1);

        for (int a = 0; a < N; a++)
            check($sformatf("mem[%0d]", a), 32'(sink[a]), 32'(exp_mem[a]));
        check("sink_peak",   32'(sink[8256]),      32'h00);
        check("sink_ramp",   32'(sink[5*W + 40]),  32'hD6);
        check("sink_border", 32'(sink[0*W + 5]),   32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
